key_conditioner: RTL and testbench

Conditions the raw, active-low DE10-Lite push-buttons (KEY) before any lab logic consumes them. Each key gets a two-flop synchronizer, a counter-based debouncer, and press/release edge detection, all in the CLOCK_50 domain. Outputs are a clean active-high level and single-cycle press/release pulses. Lab top levels instantiate it between the KEY pins and their control logic, replacing direct use of KEY[n] as a load or reset strobe.

---
 rtl/key_conditioner_pkg.sv | 21 ++
 rtl/key_conditioner_if.sv | 23 ++
 rtl/key_debounce.sv | 74 +++++++
 rtl/key_conditioner.sv | 35 +++
 tb/tb_key_conditioner.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared constants and helpers for the push-button conditioning path.
package key_conditioner_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Converts a hold time in milliseconds into CLOCK_50 cycles.
  function automatic int msToCycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES_DEF = msToCycles(DEBOUNCE_MS);

  // Edge decision for one key on one clock edge.
  typedef enum logic [1:0] {
    EDGE_NONE    = 2'd0,
    EDGE_PRESS   = 2'd1,
    EDGE_RELEASE = 2'd2
  } keyEdge_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Raw key pins in, conditioned level and edge pulses out.
interface key_conditioner_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer, qualification counter, stable level,
// and registered press/release pulses.
module key_debounce
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic keyN,
  output logic level,
  output logic pressPulse,
  output logic releasePulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             keySyncP0;
  logic             keySyncP1;
  logic             sample;
  logic             stable;
  logic [CNT_W-1:0] holdCnt;
  logic             pressP2;
  logic             releaseP2;
  keyEdge_t         keyEdge;

  // Stage 0/1: bring the asynchronous pin into CLOCK_50; reset refills with "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      keySyncP0 <= 1'b1;
      keySyncP1 <= 1'b1;
    end else begin
      keySyncP0 <= keyN;
      keySyncP1 <= keySyncP0;
    end
  end

  assign sample = ~keySyncP1;

  // Decide whether this edge accepts a change, and in which direction.
  always_comb begin
    keyEdge = EDGE_NONE;
    if ((sample != stable) && (holdCnt == CNT_MAX)) begin
      keyEdge = sample ? EDGE_PRESS : EDGE_RELEASE;
    end
  end

  // Stage 2: count consecutive disagreeing samples; any agreement restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable    <= 1'b0;
      holdCnt   <= '0;
      pressP2   <= 1'b0;
      releaseP2 <= 1'b0;
    end else begin
      pressP2   <= (keyEdge == EDGE_PRESS);
      releaseP2 <= (keyEdge == EDGE_RELEASE);
      if (sample == stable) begin
        holdCnt <= '0;
      end else if (keyEdge != EDGE_NONE) begin
        stable  <= sample;
        holdCnt <= '0;
      end else begin
        holdCnt <= holdCnt + 1'b1;
      end
    end
  end

  assign level        = stable;
  assign pressPulse   = pressP2;
  assign releasePulse = releaseP2;

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS active-low push-buttons into clean active-high levels
// and single-cycle press/release pulses. Keys are fully independent.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic               CLOCK_50,
  input logic               reset,
  key_conditioner_if.slave  keyBus
);

  logic [NUM_KEYS-1:0] levelVec;
  logic [NUM_KEYS-1:0] pressVec;
  logic [NUM_KEYS-1:0] releaseVec;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : gKey
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebounce (
      .clk          (CLOCK_50),
      .rst          (reset),
      .keyN         (keyBus.KEY[i]),
      .level        (levelVec[i]),
      .pressPulse   (pressVec[i]),
      .releasePulse (releaseVec[i])
    );
  end

  assign keyBus.key_level   = levelVec;
  assign keyBus.key_press   = pressVec;
  assign keyBus.key_release = releaseVec;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a sliding-window reference model.
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int D  = 4;
  localparam int H  = D + 2;

  logic clk;
  logic reset;
  int   nAssert;
  int   nFail;

  key_conditioner_if #(.NUM_KEYS(NK)) keyBus ();

  key_conditioner #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .keyBus   (keyBus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: pressed history of raw pins per edge. A change to value v is
  // accepted when the D pin samples taken 2..D+1 edges ago all read v and v differs
  // from the current level (two edges of synchronizer delay before qualification).
  bit             hist [NK][H];
  logic [NK-1:0]  mLevel;
  logic [NK-1:0]  mPress;
  logic [NK-1:0]  mRelease;
  bit             modelOn = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NK; k++)
        for (int j = 0; j < H; j++) hist[k][j] = 1'b0;
      mLevel   = '0;
      mPress   = '0;
      mRelease = '0;
      modelOn  = 1'b1;
    end else begin
      for (int k = 0; k < NK; k++) begin
        bit v;
        bit same;
        for (int j = H - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = ~keyBus.KEY[k];
        v    = hist[k][2];
        same = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (hist[k][j] != v) same = 1'b0;
        mPress[k]   = 1'b0;
        mRelease[k] = 1'b0;
        if (same && (v != mLevel[k])) begin
          mLevel[k]   = v;
          mPress[k]   = v;
          mRelease[k] = ~v;
        end
      end
    end
  end

  // Every cycle once the model is running, DUT outputs must match the model.
  always @(negedge clk) begin
    if (modelOn) begin
      chk("model_level",   32'(keyBus.key_level),   32'(mLevel));
      chk("model_press",   32'(keyBus.key_press),   32'(mPress));
      chk("model_release", 32'(keyBus.key_release), 32'(mRelease));
    end
  end

  initial begin
    int pulses;
    nAssert = 0;
    nFail   = 0;
    reset   = 1'b1;
    keyBus.KEY = 4'b1111;

    // Reset for 3 cycles, then 20 quiet cycles.
    step(3);
    chk("rst_level", 32'(keyBus.key_level), 32'h0);
    chk("rst_pulses", 32'(keyBus.key_press | keyBus.key_release), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_level", 32'(keyBus.key_level), 32'h0);
      chk("idle_pulses", 32'(keyBus.key_press | keyBus.key_release), 32'h0);
    end

    // Clean press on KEY[0].
    keyBus.KEY = 4'b1110;
    step(5);
    chk("press0_early", 32'(keyBus.key_level), 32'h0);
    step(1);
    chk("press0_level", 32'(keyBus.key_level), 32'h1);
    chk("press0_pulse", 32'(keyBus.key_press), 32'h1);
    step(1);
    chk("press0_pulse_end", 32'(keyBus.key_press), 32'h0);
    chk("press0_hold", 32'(keyBus.key_level), 32'h1);

    // Bounce on KEY[1]: 0,1,0,1,0,1 then idle high.
    for (int i = 0; i < 6; i++) begin
      keyBus.KEY[1] = (i % 2 == 1);
      step(1);
      chk("bounce_press", 32'(keyBus.key_press[1]), 32'h0);
    end
    keyBus.KEY[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("bounce_level", 32'(keyBus.key_level[1]), 32'h0);
      chk("bounce_pulse", 32'(keyBus.key_press[1] | keyBus.key_release[1]), 32'h0);
    end

    // 3-cycle low glitch on KEY[1] is one sample short of qualifying.
    keyBus.KEY[1] = 1'b0;
    step(3);
    keyBus.KEY[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_level", 32'(keyBus.key_level[1]), 32'h0);
      chk("glitch_press", 32'(keyBus.key_press[1]), 32'h0);
    end

    // Release KEY[0].
    keyBus.KEY[0] = 1'b1;
    step(5);
    chk("rel0_early_level", 32'(keyBus.key_level), 32'h1);
    chk("rel0_early_pulse", 32'(keyBus.key_release), 32'h0);
    step(1);
    chk("rel0_level", 32'(keyBus.key_level), 32'h0);
    chk("rel0_pulse", 32'(keyBus.key_release), 32'h1);
    step(1);
    chk("rel0_pulse_end", 32'(keyBus.key_release), 32'h0);

    // Simultaneous press of KEY[3:2].
    keyBus.KEY = 4'b0011;
    step(5);
    chk("dual_early", 32'(keyBus.key_press), 32'h0);
    step(1);
    chk("dual_press", 32'(keyBus.key_press), 32'hC);
    step(1);
    chk("dual_press_end", 32'(keyBus.key_press), 32'h0);
    chk("dual_level", 32'(keyBus.key_level), 32'hC);
    keyBus.KEY = 4'b1111;
    step(6);
    chk("dual_release", 32'(keyBus.key_release), 32'hC);
    step(2);

    // Reset two counts into a KEY[1] press; count restarts after reset drops.
    keyBus.KEY = 4'b1101;
    step(4);
    chk("midrst_pre", 32'(keyBus.key_level), 32'h0);
    reset = 1'b1;
    step(1);
    chk("midrst_level", 32'(keyBus.key_level), 32'h0);
    chk("midrst_pulses", 32'(keyBus.key_press | keyBus.key_release), 32'h0);
    reset = 1'b0;
    step(5);
    chk("midrst_early", 32'(keyBus.key_press), 32'h0);
    step(1);
    chk("midrst_press", 32'(keyBus.key_press), 32'h2);
    chk("midrst_level_up", 32'(keyBus.key_level), 32'h2);
    keyBus.KEY = 4'b1111;
    step(8);

    // KEY[2] held low through reset: exactly one press, full latency after reset.
    keyBus.KEY = 4'b1011;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (keyBus.key_press[2]) pulses++;
      if (i == 5) chk("held_early", 32'(keyBus.key_press), 32'h0);
      if (i == 6) chk("held_press", 32'(keyBus.key_press), 32'h4);
    end
    chk("held_count", 32'(pulses), 32'd1);
    keyBus.KEY = 4'b1111;
    step(8);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
